// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer for sine_wave: steps phaseStep from a start value to a
// stop value, holding each value for a programmable dwell, and owns the generator reset.
module sine_sweep_ctrl #(
  parameter int PHASE_SIZE = 8,
  parameter int DWELL_SIZE = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         loop_mode,
  input  logic signed [PHASE_SIZE:0]   cfg_phase,
  input  logic signed [PHASE_SIZE:0]   cfg_step_start,
  input  logic signed [PHASE_SIZE:0]   cfg_step_stop,
  input  logic        [PHASE_SIZE-1:0] cfg_step_inc,
  input  logic        [DWELL_SIZE-1:0] cfg_dwell,
  output logic signed [PHASE_SIZE:0]   phase,
  output logic signed [PHASE_SIZE:0]   phaseStep,
  output logic                         gen_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         step_strobe
);

  localparam int W  = PHASE_SIZE + 1;
  localparam int EW = PHASE_SIZE + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic signed [W-1:0]     phase_q, phase_d;
  logic signed [W-1:0]     phase_step_q, phase_step_d;
  logic                    gen_reset_q, gen_reset_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    step_strobe_q, step_strobe_d;
  logic [DWELL_SIZE-1:0]   dwell_cnt_q, dwell_cnt_d;
  logic                    dir_up_q, dir_up_d;

  // Shadow copy of the configuration taken when a sweep is accepted
  logic signed [W-1:0]     sh_phase_q, sh_phase_d;
  logic signed [W-1:0]     sh_start_q, sh_start_d;
  logic signed [W-1:0]     sh_stop_q, sh_stop_d;
  logic [PHASE_SIZE-1:0]   sh_inc_q, sh_inc_d;
  logic [DWELL_SIZE-1:0]   sh_dwell_q, sh_dwell_d;
  logic                    sh_loop_q, sh_loop_d;

  logic signed [EW-1:0]    cur_ext;
  logic signed [EW-1:0]    stop_ext;
  logic signed [EW-1:0]    inc_ext;
  logic signed [EW-1:0]    up_sum;
  logic signed [EW-1:0]    dn_diff;
  logic signed [W-1:0]     next_step;
  logic [DWELL_SIZE-1:0]   last_dwell_cnt;
  logic                    last_dwell;
  logic                    at_stop;

  // Step arithmetic is done one bit wider so the unclamped sum cannot wrap
  always_comb begin
    cur_ext  = {phase_step_q[W-1], phase_step_q};
    stop_ext = {sh_stop_q[W-1], sh_stop_q};
    inc_ext  = {2'b00, sh_inc_q};
    up_sum   = cur_ext + inc_ext;
    dn_diff  = cur_ext - inc_ext;
    if (dir_up_q) begin
      next_step = (up_sum >= stop_ext) ? sh_stop_q : up_sum[W-1:0];
    end else begin
      next_step = (dn_diff <= stop_ext) ? sh_stop_q : dn_diff[W-1:0];
    end
    last_dwell_cnt = sh_dwell_q - DWELL_SIZE'(1);
    last_dwell     = (dwell_cnt_q == last_dwell_cnt);
    at_stop        = (phase_step_q == sh_stop_q);
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    phase_step_d  = phase_step_q;
    gen_reset_d   = gen_reset_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    step_strobe_d = 1'b0;
    dwell_cnt_d   = dwell_cnt_q;
    dir_up_d      = dir_up_q;
    sh_phase_d    = sh_phase_q;
    sh_start_d    = sh_start_q;
    sh_stop_d     = sh_stop_q;
    sh_inc_d      = sh_inc_q;
    sh_dwell_d    = sh_dwell_q;
    sh_loop_d     = sh_loop_q;

    case (state_q)
      ST_IDLE: begin
        gen_reset_d = 1'b1;
        busy_d      = 1'b0;
        if (start && !abort) begin
          sh_phase_d  = cfg_phase;
          sh_start_d  = cfg_step_start;
          sh_stop_d   = cfg_step_stop;
          sh_inc_d    = (cfg_step_inc == '0) ? PHASE_SIZE'(1) : cfg_step_inc;
          sh_dwell_d  = (cfg_dwell == '0) ? DWELL_SIZE'(1) : cfg_dwell;
          sh_loop_d   = loop_mode;
          state_d     = ST_LOAD;
          busy_d      = 1'b1;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          gen_reset_d = 1'b1;
          dwell_cnt_d = '0;
        end else begin
          phase_d      = sh_phase_q;
          phase_step_d = sh_start_q;
          dwell_cnt_d  = '0;
          dir_up_d     = (sh_stop_q >= sh_start_q);
          state_d      = ST_DWELL;
          busy_d       = 1'b1;
          gen_reset_d  = 1'b0;
        end
      end

      ST_DWELL: begin
        if (abort) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          gen_reset_d = 1'b1;
          dwell_cnt_d = '0;
        end else if (last_dwell) begin
          dwell_cnt_d = '0;
          if (!at_stop) begin
            phase_step_d  = next_step;
            step_strobe_d = 1'b1;
          end else if (sh_loop_q) begin
            // Looping restarts the ramp without touching the generator reset
            phase_step_d  = sh_start_q;
            step_strobe_d = 1'b1;
          end else begin
            state_d     = ST_DONE;
            busy_d      = 1'b0;
            gen_reset_d = 1'b1;
            done_d      = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DWELL_SIZE'(1);
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        gen_reset_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        busy_d      = 1'b0;
        gen_reset_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      phase_step_q  <= '0;
      gen_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      step_strobe_q <= 1'b0;
      dwell_cnt_q   <= '0;
      dir_up_q      <= 1'b1;
      sh_phase_q    <= '0;
      sh_start_q    <= '0;
      sh_stop_q     <= '0;
      sh_inc_q      <= PHASE_SIZE'(1);
      sh_dwell_q    <= DWELL_SIZE'(1);
      sh_loop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      phase_step_q  <= phase_step_d;
      gen_reset_q   <= gen_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      step_strobe_q <= step_strobe_d;
      dwell_cnt_q   <= dwell_cnt_d;
      dir_up_q      <= dir_up_d;
      sh_phase_q    <= sh_phase_d;
      sh_start_q    <= sh_start_d;
      sh_stop_q     <= sh_stop_d;
      sh_inc_q      <= sh_inc_d;
      sh_dwell_q    <= sh_dwell_d;
      sh_loop_q     <= sh_loop_d;
    end
  end

  assign phase       = phase_q;
  assign phaseStep   = phase_step_q;
  assign gen_reset   = gen_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_strobe = step_strobe_q;

endmodule

// File: doc/sine_sweep_ctrl.md
Name: sine_sweep_ctrl

Overview:
Sequencer that drives the phase and phaseStep inputs of the sine_wave generator. It runs programmable frequency sweeps: phaseStep moves from a start value to a stop value in fixed increments, and each value is held for a programmable number of clock cycles. It also controls the generator's reset so every sweep starts from a clean phase accumulator. It sits between the control/register logic and signal_gen_top/sine_wave.

Parameters:
PHASE_SIZE, 8, phase/phaseStep magnitude bits; buses are PHASE_SIZE+1 bits signed, matching sine_wave
DWELL_SIZE, 16, width of dwell counter and cfg_dwell

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  sweep request; sampled only in IDLE
abort  input  1  terminate sweep; has priority over start
loop_mode  input  1  0 = single sweep, 1 = repeat until abort
cfg_phase  input  PHASE_SIZE+1 signed  phase offset applied to generator
cfg_step_start  input  PHASE_SIZE+1 signed  first phaseStep value
cfg_step_stop  input  PHASE_SIZE+1 signed  last phaseStep value
cfg_step_inc  input  PHASE_SIZE unsigned  increment magnitude per step
cfg_dwell  input  DWELL_SIZE  cycles held at each phaseStep value
phase  output  PHASE_SIZE+1 signed  to sine_wave.phase
phaseStep  output  PHASE_SIZE+1 signed  to sine_wave.phaseStep
gen_reset  output  1  to sine_wave.reset
busy  output  1  high in LOAD and DWELL
done  output  1  one-cycle pulse when a single sweep completes
step_strobe  output  1  one-cycle pulse whenever phaseStep changes value during DWELL

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE, phase=0, phaseStep=0, gen_reset=1, busy=0, done=0, step_strobe=0, dwell counter=0.
- States: IDLE, LOAD, DWELL, DONE.
- IDLE:
  - gen_reset=1; phase and phaseStep hold their last values.
  - If start=1 and abort=0: capture all cfg_* and loop_mode into shadow registers, then go to LOAD.
  - cfg_* changes after capture have no effect on the running sweep.
- LOAD (1 cycle): busy=1, gen_reset=1. Set phase=shadow phase, phaseStep=shadow start, dwell counter=0, direction = up if stop >= start, else down. Next state is DWELL.
- DWELL:
  - busy=1, gen_reset=0. Dwell counter increments each cycle.
  - Effective dwell = max(cfg_dwell, 1); effective inc = max(cfg_step_inc, 1).
  - On the last dwell cycle (counter = effective dwell - 1), counter clears and one of the following applies:
    - phaseStep != stop: phaseStep moves by ±inc, clamped to stop. step_strobe=1 next cycle. Stay in DWELL.
    - phaseStep == stop and loop_mode=1: phaseStep=start, step_strobe=1, stay in DWELL. gen_reset is not pulsed.
    - phaseStep == stop and loop_mode=0: go to DONE.
- DONE (1 cycle): done=1, busy=0, gen_reset=1. Next state is IDLE.
- Arithmetic: sign-extend to PHASE_SIZE+2 bits, add/subtract inc, compare against stop, and clamp. The result always lies between start and stop, so no overflow is possible.
- start=stop: one dwell period, then DONE (or repeat in loop mode).
- abort=1 in LOAD, DWELL or DONE: next state is IDLE, gen_reset=1, busy=0, done is not asserted, step_strobe=0. abort in IDLE is a no-op. If start=1 and abort=1 together, abort wins.
- start while busy is ignored; no queuing.
- Total single-sweep busy time: 1 + N_steps × effective dwell cycles.

Test Plan:
- Up-sweep: start=0, stop=4, inc=1, dwell=3, single. Required: phaseStep 0,1,2,3,4, each held 3 cycles with gen_reset=0; 4 step_strobes; busy high 16 cycles; done pulses once; gen_reset returns to 1.
- Down-sweep with clamp: start=10, stop=-3, inc=4, dwell=2. Required: phaseStep 10,6,2,-2,-3; done after 10 DWELL cycles.
- Loop mode: start=-2, stop=2, inc=2, dwell=1, loop. Required: phaseStep cycles -2,0,2,-2,… with no done and gen_reset held 0. Abort during the third pass: IDLE next cycle, gen_reset=1, done=0.
- Degenerate config: dwell=0, inc=0, start=stop=5. Required: 1 DWELL cycle at phaseStep=5, then done. Separately, start=0, stop=3, inc=0 gives phaseStep 0,1,2,3.
- Handshake: start pulsed during DWELL, and start+abort asserted together in IDLE. Required: both ignored, and the running sweep is unchanged.
- Async reset asserted mid-DWELL, off a clock edge. Required: outputs go immediately to phase=0, phaseStep=0, gen_reset=1, busy=0. After reset releases, a fresh start completes normally.
